nmr_rx_capture: RTL and testbench
=================================

// Module: nmr_rx_capture
// PURPOSE
//  Receive-side counterpart of the pulse generator. Captures the FID echo after an excitation pulse.
//  - Watches en_gen and arms on its falling edge (end of RF pulse).
//  - Discards a dead-time of ADC samples, then sums each group of D samples (boxcar decimation).
//  - Streams the sums, cfg_len words per record, on an AXI4-Stream master through a small FIFO.
//  - Sits between the ADC AXIS feed (14-bit) and the DMA/readout path.
// PARAMETERS
//  ADC_W       14  ADC sample width, signed two's complement
//  DEC_W        8  width of cfg_dec; accumulator width = ADC_W+DEC_W
//  CNT_W       16  width of cfg_dead / cfg_len counters
//  FIFO_DEPTH   4  output FIFO entries, power of 2, >=2
// PORTS
//  clk_125MHz        in   1      system clock, all logic rising-edge
//  rst               in   1      asynchronous reset, active-high
//  en_gen            in   1      generator enable; 1->0 transition = capture trigger
//  s_axis_adc_tdata  in   ADC_W  ADC sample, signed
//  s_axis_adc_tvalid in   1      sample valid (no tready; ADC never stalls)
//  cfg_dead          in   CNT_W  valid samples to discard after trigger
//  cfg_dec           in   DEC_W  decimation factor D; 0 treated as 1
//  cfg_len           in   CNT_W  output words per record; 0 = no record
//  m_axis_tdata      out  32     decimated sum, sign-extended from ADC_W+DEC_W
//  m_axis_tvalid     out  1      FIFO non-empty
//  m_axis_tready     in   1      downstream ready
//  m_axis_tlast      out  1      marks final word of record
//  busy              out  1      1 while state != IDLE
//  overrun           out  1      sticky: a word was dropped on FIFO full
// BEHAVIOUR
//  Reset
//  - Async rst: state=IDLE, counters/accumulator=0, FIFO empty.
//  - All outputs 0; en_gen history register=0.
//  Trigger
//  - en_q <= en_gen each cycle; trig = en_q & ~en_gen.
//  - On trig in IDLE, latch cfg_dead, cfg_dec, cfg_len.
//  - Config changes mid-record have no effect.
//  FSM (IDLE, DEAD, ACQ)
//  - IDLE + trig: len==0 -> stay IDLE; dead==0 -> ACQ; else DEAD.
//  - DEAD: count valid samples; after exactly cfg_dead discarded -> ACQ.
//    The next valid sample is the first one accumulated.
//  - ACQ: on each valid sample, acc += sample (signed).
//  - ACQ, D-th sample: push acc+sample to FIFO, clear acc, word_cnt++.
//  - ACQ, push of word cfg_len: push carries tlast=1, state -> IDLE the next cycle.
//  - trig outside IDLE is ignored; rising en_gen is always ignored.
//  - Invalid-sample cycles advance nothing.
//  Output
//  - Latency: push in cycle N+1 after the D-th sample is accepted in cycle N.
//  - m_axis_tvalid=1 from cycle N+2.
//  - FIFO is first-word fall-through; pop when tvalid & tready.
//  - tdata/tlast hold stable while tvalid & ~tready.
//  - Drain is independent of state; a new record may start while the FIFO still drains.
//  Full FIFO
//  - Push while full and no pop: word dropped, overrun<=1 until rst.
//  - A dropped word still counts toward cfg_len; a dropped tlast word is lost.
//  - Push and pop in the same cycle while full: push accepted, no drop.
//  Arithmetic
//  - Accumulator is ADC_W+DEC_W bits signed; D<=2^DEC_W-1, so it never overflows.
//  - Sign-extend the accumulator to 32 bits.
//  Reset mid-record: returns to IDLE at once, FIFO flushed, no tlast emitted.
// TESTING
//  T1
//  - dead=3, dec=1, len=4, ADC ramp 0,1,2..., trig, tready=1.
//  - Expect words 3,4,5,6; tlast only on 6.
//  - Expect busy low 1 cycle after the 4th push.
//  T2
//  - dec=4, len=2, constant -8192, dead=0.
//  - Expect two words 0xFFFF8000, tlast on the 2nd.
//  T3
//  - dec=1, len=6, tready=0 throughout.
//  - Expect 4 words held (values stable) and 2 dropped; overrun=1.
//  - Then tready=1: exactly 4 words out, no tlast.
//  T4
//  - tvalid toggling 1/0, dec=2, len=3, ramp.
//  - Expect sums of consecutive valid samples only (1, 5, 9 for ramp 0..5).
//  T5
//  - Second en_gen falling edge during ACQ: no restart, word count unchanged.
//  - len=0 trig: no output, busy stays 0.
//  T6
//  - rst pulse during ACQ with 2 words queued: tvalid=0, busy=0, overrun=0 next cycle.
//  - Next trig starts a clean record.

Source files
------------

// File: rtl/nmr_rx_capture.sv
// FID capture: arms on the falling edge of en_gen, skips a dead-time, boxcar-decimates
// the ADC stream and emits fixed-length records on an AXI4-Stream master via a small FIFO.
module nmr_rx_capture #(
  parameter int ADC_W      = 14,
  parameter int DEC_W      = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_125MHz,
  input  logic             rst,
  input  logic             en_gen,
  input  logic [ADC_W-1:0] s_axis_adc_tdata,
  input  logic             s_axis_adc_tvalid,
  input  logic [CNT_W-1:0] cfg_dead,
  input  logic [DEC_W-1:0] cfg_dec,
  input  logic [CNT_W-1:0] cfg_len,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             overrun
);
  localparam int ACC_W = ADC_W + DEC_W;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW    = ACC_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DEAD = 2'd1, ACQ = 2'd2} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    en_q;
  logic                    trig;
  logic [CNT_W-1:0]        dead_r;
  logic [CNT_W-1:0]        len_r;
  logic [CNT_W-1:0]        dead_cnt;
  logic [CNT_W-1:0]        word_cnt;
  logic [DEC_W-1:0]        dec_r;
  logic [DEC_W-1:0]        samp_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] push_data;
  logic                    push_pend;
  logic                    push_last;
  logic                    final_pend;
  logic                    take;
  logic                    dec_hit;
  logic                    last_word;
  logic                    dead_done;

  logic [FW-1:0]           mem [FIFO_DEPTH];
  logic [FW-1:0]           head;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [AW:0]             count;
  logic                    full;
  logic                    pop;
  logic                    wr;

  assign trig       = en_q & ~en_gen;
  assign sample_ext = {{DEC_W{s_axis_adc_tdata[ADC_W-1]}}, s_axis_adc_tdata};
  assign sum        = acc + sample_ext;
  // Once the final word is in flight, further samples must not start a new word.
  assign final_pend = push_pend & push_last;
  assign take       = (state == ACQ) & s_axis_adc_tvalid & ~final_pend;
  assign dec_hit    = (samp_cnt == (dec_r - DEC_W'(1)));
  assign last_word  = (word_cnt == (len_r - CNT_W'(1)));
  assign dead_done  = s_axis_adc_tvalid & (dead_cnt == (dead_r - CNT_W'(1)));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (trig) begin
          if (cfg_len == '0) begin
            state_next = IDLE;
          end else if (cfg_dead == '0) begin
            state_next = ACQ;
          end else begin
            state_next = DEAD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      DEAD: begin
        if (dead_done) begin
          state_next = ACQ;
        end else begin
          state_next = DEAD;
        end
      end
      ACQ: begin
        if (final_pend) begin
          state_next = IDLE;
        end else begin
          state_next = ACQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      en_q  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      en_q  <= en_gen;
      busy  <= (state_next != IDLE);
    end
  end

  // Config latch, dead-time count and boxcar accumulation; words leave one cycle later.
  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      dead_r    <= '0;
      len_r     <= '0;
      dec_r     <= '0;
      dead_cnt  <= '0;
      word_cnt  <= '0;
      samp_cnt  <= '0;
      acc       <= '0;
      push_pend <= 1'b0;
      push_last <= 1'b0;
      push_data <= '0;
    end else begin
      push_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            dead_r    <= cfg_dead;
            len_r     <= cfg_len;
            dec_r     <= (cfg_dec == '0) ? DEC_W'(1) : cfg_dec;
            dead_cnt  <= '0;
            word_cnt  <= '0;
            samp_cnt  <= '0;
            acc       <= '0;
            push_last <= 1'b0;
          end
        end
        DEAD: begin
          if (s_axis_adc_tvalid) begin
            dead_cnt <= dead_cnt + CNT_W'(1);
          end
        end
        ACQ: begin
          if (take) begin
            if (dec_hit) begin
              push_pend <= 1'b1;
              push_data <= sum;
              push_last <= last_word;
              acc       <= '0;
              samp_cnt  <= '0;
              word_cnt  <= word_cnt + CNT_W'(1);
            end else begin
              acc      <= sum;
              samp_cnt <= samp_cnt + DEC_W'(1);
            end
          end
        end
        default: begin
          push_pend <= 1'b0;
        end
      endcase
    end
  end

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = (count != '0) & m_axis_tready;
  assign wr   = push_pend & (~full | pop);
  assign head = mem[rd_ptr];

  // Storage needs no reset: reads are masked by the occupancy count.
  always_ff @(posedge clk_125MHz) begin
    if (wr) begin
      mem[wr_ptr] <= {push_last, push_data};
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_pend & full & ~pop) begin
        overrun <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ?
                         {{(32-ACC_W){head[ACC_W-1]}}, head[ACC_W-1:0]} : 32'd0;
  assign m_axis_tlast  = m_axis_tvalid & head[ACC_W];

endmodule

// File: tb/tb_nmr_rx_capture.sv
// Self-checking bench for nmr_rx_capture: table of record configurations checked against
// a sample-list reference model, plus hand sequences for overrun, re-trigger and reset.
module tb_nmr_rx_capture;
  logic        clk = 1'b0;
  logic        rst;
  logic        en_gen;
  logic [13:0] s_tdata;
  logic        s_tvalid;
  logic [15:0] cfg_dead;
  logic [7:0]  cfg_dec;
  logic [15:0] cfg_len;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        overrun;

  typedef struct {
    int          dead;
    int          dec;
    int          len;
    int          vmode;      // 0 always valid, 1 toggling, 2 random
    int          dmode;      // 0 ramp, 1 constant -8192, 2 random
    int          rmode;      // 0 tready=1, 1 random tready
    int          chk_first;
    logic [31:0] first;
  } vec_t;

  vec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  logic [32:0] got[$];
  logic        stall = 1'b0;
  logic [32:0] prev_word;

  nmr_rx_capture dut (
    .clk_125MHz       (clk),
    .rst              (rst),
    .en_gen           (en_gen),
    .s_axis_adc_tdata (s_tdata),
    .s_axis_adc_tvalid(s_tvalid),
    .cfg_dead         (cfg_dead),
    .cfg_dec          (cfg_dec),
    .cfg_len          (cfg_len),
    .m_axis_tdata     (m_tdata),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tlast     (m_tlast),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #4 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: records accepted beats and checks stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      got.delete();
      stall = 1'b0;
    end else begin
      if (stall) chk("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_word});
      if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
      stall     = m_tvalid & ~m_tready;
      prev_word = {m_tlast, m_tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic arm(input int dead, input int dec, input int len);
    @(posedge clk); #1;
    cfg_dead = 16'(dead); cfg_dec = 8'(dec); cfg_len = 16'(len);
    en_gen = 1'b1; s_tvalid = 1'b0;
    @(posedge clk); #1;
    en_gen = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((m_tvalid || busy) && k < 2000) begin
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      k++;
    end
    chk({tag, " drain timeout"}, 64'(k < 2000), 64'd1);
  endtask

  task automatic run_record(input vec_t v, input int idx);
    int   d, need, vcnt, s;
    logic tog;
    logic [13:0] smp;
    int   samples[$];
    logic [32:0] exp_w;
    d    = (v.dec == 0) ? 1 : v.dec;
    need = v.dead + d * v.len;
    vcnt = 0;
    tog  = 1'b1;
    got.delete();
    arm(v.dead, v.dec, v.len);
    while (vcnt < need) begin
      @(posedge clk); #1;
      s_tvalid = (v.vmode == 0) ? 1'b1 : (v.vmode == 1) ? tog : 1'b1 & (($urandom % 3) != 0);
      tog = ~tog;
      smp = (v.dmode == 0) ? 14'(vcnt) : (v.dmode == 1) ? 14'h2000 : 14'($urandom);
      s_tdata = s_tvalid ? smp : 14'($urandom);
      if (s_tvalid) begin
        samples.push_back(int'($signed(smp)));
        vcnt++;
      end
      m_tready = (v.rmode == 0) ? 1'b1 : 1'b1 & (($urandom % 4) != 0);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("rec%0d busy at push", idx), 64'(busy), 64'd1);
    @(negedge clk);
    chk($sformatf("rec%0d busy after push", idx), 64'(busy), 64'd0);
    chk($sformatf("rec%0d tvalid after push", idx), 64'(m_tvalid), 64'd1);
    drain($sformatf("rec%0d", idx));
    chk($sformatf("rec%0d word count", idx), 64'(got.size()), 64'(v.len));
    for (int w = 0; w < v.len && w < got.size(); w++) begin
      s = 0;
      for (int j = 0; j < d; j++) s += samples[v.dead + w * d + j];
      exp_w = {(w == v.len - 1) ? 1'b1 : 1'b0, 32'(s)};
      chk($sformatf("rec%0d word%0d", idx, w), 64'(got[w]), 64'(exp_w));
    end
    if (v.chk_first != 0 && got.size() > 0)
      chk($sformatf("rec%0d first", idx), 64'(got[0][31:0]), 64'(v.first));
  endtask

  initial begin
    vecs[0] = '{3, 1, 4, 0, 0, 0, 1, 32'd3};
    vecs[1] = '{0, 4, 2, 0, 1, 0, 1, 32'hFFFF8000};
    vecs[2] = '{0, 2, 3, 1, 0, 0, 1, 32'd1};
    vecs[3] = '{2, 0, 3, 0, 2, 0, 0, 32'd0};
    vecs[4] = '{5, 3, 5, 2, 2, 1, 0, 32'd0};
    vecs[5] = '{0, 7, 4, 2, 2, 1, 0, 32'd0};
    vecs[6] = '{1, 255, 2, 2, 2, 1, 0, 32'd0};
    vecs[7] = '{4, 5, 1, 2, 0, 1, 0, 32'd0};

    rst = 1'b1; en_gen = 1'b0; s_tdata = 14'd0; s_tvalid = 1'b0;
    cfg_dead = 16'd0; cfg_dec = 8'd1; cfg_len = 16'd0; m_tready = 1'b0;
    @(negedge clk);
    chk("reset tvalid", 64'(m_tvalid), 64'd0);
    chk("reset tlast", 64'(m_tlast), 64'd0);
    chk("reset tdata", 64'(m_tdata), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset overrun", 64'(overrun), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_record(vecs[i], i);
    chk("no overrun in table", 64'(overrun), 64'd0);

    // Stalled sink: four words held, the remaining two (including tlast) dropped.
    m_tready = 1'b0;
    got.delete();
    arm(0, 1, 6);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = 14'(i);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t3 overrun", 64'(overrun), 64'd1);
    chk("t3 tvalid", 64'(m_tvalid), 64'd1);
    chk("t3 head", 64'(m_tdata), 64'd0);
    chk("t3 busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t3 count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("t3 word%0d", i), 64'(got[i]), 64'(i));

    // Re-trigger during acquisition and config changes mid-record are ignored.
    got.delete();
    arm(0, 2, 3);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = 14'(i);
      if (i == 2) en_gen = 1'b1;
      if (i == 3) begin
        en_gen = 1'b0; cfg_len = 16'd1; cfg_dec = 8'd1; cfg_dead = 16'd5;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    drain("t5");
    chk("t5 count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("t5 w0", 64'(got[0]), 64'h0_0000_0001);
      chk("t5 w1", 64'(got[1]), 64'h0_0000_0005);
      chk("t5 w2", 64'(got[2]), 64'h1_0000_0009);
    end

    // Zero-length record never leaves IDLE.
    got.delete();
    arm(0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = 14'(i + 7);
      @(negedge clk);
      chk($sformatf("len0 busy%0d", i), 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("len0 words", 64'(got.size()), 64'd0);
    chk("len0 tvalid", 64'(m_tvalid), 64'd0);

    // Reset mid-record with two words queued.
    m_tready = 1'b0;
    arm(0, 1, 5);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = 14'(i + 20);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6 pre tvalid", 64'(m_tvalid), 64'd1);
    chk("t6 pre busy", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6 tvalid", 64'(m_tvalid), 64'd0);
    chk("t6 busy", 64'(busy), 64'd0);
    chk("t6 overrun", 64'(overrun), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_tready = 1'b1;
    run_record(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
